// File: rtl/mem_paged_pkg.sv
// rtl/mem_paged_pkg.sv - shared types for the paged main-memory block
package mem_paged_pkg;

    localparam int CNT_BITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    typedef enum logic {
        ACC_RD,
        ACC_WR
    } acc_t;

    typedef enum logic [1:0] {
        REG_FIXED,
        REG_WINDOW,
        REG_BANKREG
    } region_t;

endpackage

// File: rtl/mem_paged_array.sv
// rtl/mem_paged_array.sv - single-port byte array, synchronous write, asynchronous read
module mem_paged_array #(
    parameter int             AW   = 16,
    parameter int             W    = 8,
    parameter logic [W-1:0]   INIT = '0
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW] = '{default: INIT};

    // write port; the read path is combinational so the caller can register it on commit
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_paged.sv
// rtl/mem_paged.sv - paged, wait-stated main memory; MEM_PAGED_WP_EN enables write protection below ROM_TOP
module mem_paged
    import mem_paged_pkg::*;
#(
    parameter int                    WIDTH_ADDR    = 16,
    parameter int                    WIDTH         = 8,
    parameter int                    BANK_BITS     = 2,
    parameter int                    WINDOW_BITS   = 14,
    parameter logic [WIDTH_ADDR-1:0] WINDOW_BASE   = 16'h8000,
    parameter logic [WIDTH_ADDR-1:0] BANK_REG_ADDR = 16'hFFFF,
    parameter int                    WAIT_STATES   = 1,
    parameter logic [WIDTH_ADDR-1:0] ROM_TOP       = 16'h2000,
    parameter logic [WIDTH-1:0]      DEFAULT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_ADDR-1:0] addr_in,
    input  logic                  bus_dir,
    input  logic [WIDTH-1:0]      main_in,
    input  logic                  assert_main,
    input  logic                  load_main,
    output logic [WIDTH-1:0]      main_out,
    output logic                  main_en,
    output logic [WIDTH-1:0]      bus_out,
    output logic                  ready,
    output logic [BANK_BITS-1:0]  bank_out,
    output logic                  wp_fault
);

    localparam int BIDX_BITS = BANK_BITS + WINDOW_BITS;

    state_t                state, state_nx;
    logic [CNT_BITS-1:0]   cnt;
    logic [BANK_BITS-1:0]  bank;
    logic [WIDTH_ADDR-1:0] lat_addr;
    logic [WIDTH-1:0]      lat_data;
    logic [BANK_BITS-1:0]  lat_bank;
    acc_t                  lat_type;

    logic                  wr_req, rd_req, any_req, same_acc, start, commit, wp_block;
    acc_t                  cur_type, c_type;
    logic [WIDTH_ADDR-1:0] c_addr;
    logic [WIDTH-1:0]      c_data;
    logic [BANK_BITS-1:0]  c_bank;
    region_t               c_region;
    logic                  fix_we, bnk_we;
    logic [WIDTH-1:0]      fix_rdata, bnk_rdata;
    logic [BIDX_BITS-1:0]  bnk_addr;

    function automatic region_t region_of(input logic [WIDTH_ADDR-1:0] a);
        if (a == BANK_REG_ADDR) begin
            return REG_BANKREG;
        end else if (a[WIDTH_ADDR-1:WINDOW_BITS] == WINDOW_BASE[WIDTH_ADDR-1:WINDOW_BITS]) begin
            return REG_WINDOW;
        end else begin
            return REG_FIXED;
        end
    endfunction

    // request decode and FSM next-state; a new access commits at once when there are no wait states
    always_comb begin
        wr_req   = !load_main && !bus_dir;
        rd_req   = !assert_main && bus_dir;
        any_req  = wr_req || rd_req;
        cur_type = rd_req ? ACC_RD : ACC_WR;
        same_acc = (cur_type == lat_type) && (addr_in == lat_addr);
        state_nx = state;
        start    = 1'b0;
        commit   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) start = 1'b1;
            end
            ST_BUSY: begin
                if (!any_req) begin
                    state_nx = ST_IDLE;
                end else if (cnt == '0) begin
                    commit   = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!any_req) state_nx = ST_IDLE;
                else if (!same_acc) start = 1'b1;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (start) begin
            if (WAIT_STATES == 0) begin
                commit   = 1'b1;
                state_nx = ST_DONE;
            end else begin
                state_nx = ST_BUSY;
            end
        end
        // commit target comes from the live bus on a zero-wait start, otherwise from the latches
        c_type   = start ? cur_type : lat_type;
        c_addr   = start ? addr_in  : lat_addr;
        c_data   = start ? main_in  : lat_data;
        c_bank   = start ? bank     : lat_bank;
        c_region = region_of(c_addr);
        bnk_addr = {c_bank, c_addr[WINDOW_BITS-1:0]};
        fix_we   = commit && !rst && (c_type == ACC_WR) && (c_region == REG_FIXED) && !wp_block;
        bnk_we   = commit && !rst && (c_type == ACC_WR) && (c_region == REG_WINDOW);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // access latches, wait counter, bank register and registered read data
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            bank     <= '0;
            bus_out  <= '0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_bank <= '0;
            lat_type <= ACC_RD;
        end else begin
            if (start) begin
                lat_addr <= addr_in;
                lat_data <= main_in;
                lat_bank <= bank;
                lat_type <= cur_type;
                cnt      <= CNT_BITS'(WAIT_STATES);
            end else if (state == ST_BUSY && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                if (c_type == ACC_RD) begin
                    case (c_region)
                        REG_WINDOW:  bus_out <= bnk_rdata;
                        REG_BANKREG: bus_out <= {{(WIDTH-BANK_BITS){1'b0}}, bank};
                        default:     bus_out <= fix_rdata;
                    endcase
                end else if (c_region == REG_BANKREG) begin
                    bank <= c_data[BANK_BITS-1:0];
                end
            end
        end
    end

`ifdef MEM_PAGED_WP_EN
    assign wp_block = (c_type == ACC_WR) && (c_region == REG_FIXED) && (c_addr < ROM_TOP);

    // sticky protection fault, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst)                    wp_fault <= 1'b0;
        else if (commit && wp_block) wp_fault <= 1'b1;
    end
`else
    logic unused_rom_top;
    assign unused_rom_top = ^ROM_TOP;
    assign wp_block       = 1'b0;
    assign wp_fault       = 1'b0;
`endif

    mem_paged_array #(.AW(WIDTH_ADDR), .W(WIDTH), .INIT(DEFAULT_VALUE)) u_fixed (
        .clk   (clk),
        .we    (fix_we),
        .addr  (c_addr),
        .wdata (c_data),
        .rdata (fix_rdata)
    );

    mem_paged_array #(.AW(BIDX_BITS), .W(WIDTH), .INIT(DEFAULT_VALUE)) u_banked (
        .clk   (clk),
        .we    (bnk_we),
        .addr  (bnk_addr),
        .wdata (c_data),
        .rdata (bnk_rdata)
    );

    assign ready    = (state == ST_DONE);
    assign main_en  = bus_dir && !assert_main && (state == ST_DONE);
    assign main_out = bus_dir ? bus_out : main_in;
    assign bank_out = bank;

endmodule

// File: tb/tb_mem_paged.sv
// tb/tb_mem_paged.sv - randomized self-checking bench for mem_paged against a transaction-level model
module tb_mem_paged;

    localparam int WS  = 1;
    localparam int LAT = (WS == 0) ? 0 : WS + 1;
`ifdef MEM_PAGED_WP_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr_in;
    logic        bus_dir;
    logic [7:0]  main_in;
    logic        assert_main;
    logic        load_main;
    logic [7:0]  main_out;
    logic        main_en;
    logic [7:0]  bus_out;
    logic        ready;
    logic [1:0]  bank_out;
    logic        wp_fault;

    mem_paged #(.WAIT_STATES(WS)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr_in     (addr_in),
        .bus_dir     (bus_dir),
        .main_in     (main_in),
        .assert_main (assert_main),
        .load_main   (load_main),
        .main_out    (main_out),
        .main_en     (main_en),
        .bus_out     (bus_out),
        .ready       (ready),
        .bank_out    (bank_out),
        .wp_fault    (wp_fault)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    bit         checking = 1'b0;

    logic [7:0] fmem [int];
    logic [7:0] bmem [int];
    int         m_bank  = 0;
    logic [7:0] m_bus   = 8'h00;
    bit         m_wp    = 1'b0;
    bit         m_ready = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // memory model: address ranges decoded arithmetically, window pages as flat offsets
    task automatic model_commit(input bit is_wr, input logic [15:0] a, input logic [7:0] d);
        int ia, idx;
        ia = int'(a);
        if (ia == 65535) begin
            if (is_wr) m_bank = int'(d) % 4;
            else       m_bus  = 8'(m_bank);
        end else if (ia >= 32768 && ia < 32768 + 16384) begin
            idx = m_bank * 16384 + (ia - 32768);
            if (is_wr) bmem[idx] = d;
            else       m_bus = bmem.exists(idx) ? bmem[idx] : 8'h00;
        end else begin
            if (is_wr) begin
                if (WP_EN && ia < 8192) m_wp = 1'b1;
                else                    fmem[ia] = d;
            end else begin
                m_bus = fmem.exists(ia) ? fmem[ia] : 8'h00;
            end
        end
    endtask

    // every cycle compare all outputs against the model
    always @(negedge clk) begin
        if (checking) begin
            chk("ready",    16'(ready),    16'(m_ready));
            chk("bus_out",  16'(bus_out),  16'(m_bus));
            chk("bank_out", 16'(bank_out), 16'(m_bank));
            chk("wp_fault", 16'(wp_fault), 16'(m_wp));
            chk("main_en",  16'(main_en),  16'(bus_dir && !assert_main && m_ready));
            chk("main_out", 16'(main_out), 16'(bus_dir ? m_bus : main_in));
        end
    end

    task automatic idle();
        load_main   = 1'b1;
        assert_main = 1'b1;
        bus_dir     = 1'($urandom);
        main_in     = 8'($urandom);
        addr_in     = 16'($urandom);
    endtask

    task automatic drive_req(input bit is_wr, input logic [15:0] a, input logic [7:0] d);
        addr_in = a;
        main_in = d;
        if (is_wr) begin
            bus_dir = 1'b0; load_main = 1'b0; assert_main = 1'($urandom);
        end else begin
            bus_dir = 1'b1; assert_main = 1'b0; load_main = 1'($urandom);
        end
    endtask

    task automatic access(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                          input int hold, input bit chain);
        drive_req(is_wr, a, d);
        @(posedge clk); #1;
        if (LAT == 0) begin
            model_commit(is_wr, a, d);
            m_ready = 1'b1;
        end else begin
            m_ready = 1'b0;
            repeat (LAT) begin
                main_in = 8'($urandom);
                @(posedge clk); #1;
            end
            model_commit(is_wr, a, d);
            m_ready = 1'b1;
        end
        repeat (hold) begin
            main_in = 8'($urandom);
            @(posedge clk); #1;
        end
        if (!chain) begin
            idle();
            @(posedge clk); #1;
            m_ready = 1'b0;
        end
    endtask

    task automatic end_chain();
        idle();
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic abort_write(input logic [15:0] a, input logic [7:0] d);
        drive_req(1'b1, a, d);
        @(posedge clk); #1;
        m_ready = 1'b0;
        idle();
        @(posedge clk); #1;
    endtask

    task automatic reset_mid(input logic [15:0] a, input logic [7:0] d);
        drive_req(1'b1, a, d);
        @(posedge clk); #1;
        m_ready = 1'b0;
        rst = 1'b1;
        idle();
        @(posedge clk); #1;
        m_bank = 0; m_bus = 8'h00; m_wp = 1'b0; m_ready = 1'b0;
        rst = 1'b0;
    endtask

    logic [15:0] addr_tab [12] = '{16'h0000, 16'h0010, 16'h1FFF, 16'h2000, 16'h1234, 16'h7FFF,
                                   16'h8000, 16'h8001, 16'hBFFF, 16'hC000, 16'hFFFE, 16'hFFFF};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, prev_a;
        logic [7:0]  d;
        bit          is_wr, prev_wr, chained, ch;
        int          op, sel;

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checking = 1'b1;
        chk("rst_ready", 16'(ready), 16'h0);
        chk("rst_bus",   16'(bus_out), 16'h0);
        chk("rst_bank",  16'(bank_out), 16'h0);
        chk("rst_wp",    16'(wp_fault), 16'h0);
        chk("rst_en",    16'(main_en), 16'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // basic write then read, read held in DONE to observe the bus drive
        access(1'b1, 16'h1234, 8'hA5, 0, 1'b0);
        access(1'b0, 16'h1234, 8'h00, 0, 1'b1);
        chk("lit_rd_ready", 16'(ready), 16'h1);
        chk("lit_rd_en", 16'(main_en), 16'h1);
        chk("lit_rd_main", 16'(main_out), 16'h00A5);
        end_chain();
        chk("lit_rd_bus", 16'(bus_out), 16'h00A5);
        chk("lit_en_idle", 16'(main_en), 16'h0);

        // window paging
        access(1'b1, 16'hFFFF, 8'h01, 0, 1'b0);
        chk("lit_bank1", 16'(bank_out), 16'h1);
        access(1'b1, 16'h8000, 8'h11, 0, 1'b0);
        access(1'b1, 16'hFFFF, 8'h02, 0, 1'b0);
        chk("lit_bank2", 16'(bank_out), 16'h2);
        access(1'b1, 16'h8000, 8'h22, 0, 1'b0);
        access(1'b0, 16'h8000, 8'h00, 0, 1'b0);
        chk("lit_page2", 16'(bus_out), 16'h0022);
        access(1'b1, 16'hFFFF, 8'h01, 0, 1'b0);
        access(1'b0, 16'h8000, 8'h00, 1, 1'b0);
        chk("lit_page1", 16'(bus_out), 16'h0011);
        access(1'b0, 16'hFFFF, 8'h00, 0, 1'b0);
        chk("lit_bankrd", 16'(bus_out), 16'h0001);

        // abort during the wait state
        abort_write(16'h0400, 8'h77);
        access(1'b0, 16'h0400, 8'h00, 0, 1'b0);
        chk("lit_abort", 16'(bus_out), 16'h0000);

        // reset in the middle of a write
        reset_mid(16'h0500, 8'h55);
        chk("lit_rst_bank", 16'(bank_out), 16'h0);
        access(1'b0, 16'h0500, 8'h00, 0, 1'b0);
        chk("lit_rst_mem", 16'(bus_out), 16'h0000);

        // write protection boundary
        access(1'b1, 16'h0010, 8'hFF, 0, 1'b0);
        access(1'b0, 16'h0010, 8'h00, 0, 1'b0);
        chk("lit_wp_mem", 16'(bus_out), WP_EN ? 16'h0000 : 16'h00FF);
        chk("lit_wp_flag", 16'(wp_fault), WP_EN ? 16'h1 : 16'h0);
        access(1'b1, 16'h2000, 8'h3C, 0, 1'b0);
        access(1'b0, 16'h2000, 8'h00, 0, 1'b0);
        chk("lit_rom_top", 16'(bus_out), 16'h003C);

        // back-to-back accesses without releasing the request
        access(1'b0, 16'h1234, 8'h00, 0, 1'b1);
        access(1'b0, 16'h2000, 8'h00, 0, 1'b0);
        chk("lit_chain", 16'(bus_out), 16'h003C);

        // randomized traffic
        chained = 1'b0;
        prev_a  = 16'h0;
        prev_wr = 1'b0;
        for (int i = 0; i < 400; i++) begin
            op  = $urandom_range(0, 19);
            sel = $urandom_range(0, 13);
            a   = (sel < 12) ? addr_tab[sel] : 16'($urandom);
            d   = 8'($urandom);
            if (!chained && op == 0 && WS > 0) begin
                abort_write(a, d);
            end else if (!chained && op == 1 && WS > 0) begin
                reset_mid(a, d);
            end else begin
                is_wr = 1'($urandom);
                if (chained && is_wr == prev_wr && a == prev_a) a = a ^ 16'h0001;
                ch = ($urandom_range(0, 3) == 0);
                access(is_wr, a, d, $urandom_range(0, 2), ch);
                chained = ch;
                prev_a  = a;
                prev_wr = is_wr;
            end
        end
        if (chained) end_chain();
        @(posedge clk); #1;
        checking = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
